// File: rtl/alu_request_arbiter_if.sv
// Bundle of the requester, shared-ALU and response signals of alu_request_arbiter.
// The slave modport is the arbiter view; master is the surrounding system.
interface alu_request_arbiter_if;
    logic        Req0Valid;
    logic        Req1Valid;
    logic        Req0Ready;
    logic        Req1Ready;
    logic [15:0] Req0A;
    logic [15:0] Req0B;
    logic [15:0] Req1A;
    logic [15:0] Req1B;
    logic [4:0]  Req0FunSel;
    logic [4:0]  Req1FunSel;
    logic        Req0WF;
    logic        Req1WF;
    logic [15:0] A;
    logic [15:0] B;
    logic [4:0]  FunSel;
    logic        WF;
    logic [15:0] ALUOut;
    logic [3:0]  FlagsOut;
    logic        RspValid;
    logic        RspReady;
    logic        RspId;
    logic [15:0] RspData;
    logic [3:0]  RspFlags;

    modport slave (
        input  Req0Valid, Req1Valid, Req0A, Req0B, Req1A, Req1B,
        input  Req0FunSel, Req1FunSel, Req0WF, Req1WF,
        input  ALUOut, FlagsOut, RspReady,
        output Req0Ready, Req1Ready, A, B, FunSel, WF,
        output RspValid, RspId, RspData, RspFlags
    );

    modport master (
        output Req0Valid, Req1Valid, Req0A, Req0B, Req1A, Req1B,
        output Req0FunSel, Req1FunSel, Req0WF, Req1WF,
        output ALUOut, FlagsOut, RspReady,
        input  Req0Ready, Req1Ready, A, B, FunSel, WF,
        input  RspValid, RspId, RspData, RspFlags
    );
endinterface

// File: rtl/alu_request_arbiter.sv
// Two-requester arbiter for a shared ALU: one operation in flight, walking
// IDLE -> EXEC -> FLAG -> RESP, with round-robin or fixed priority grant.
module alu_request_arbiter #(
    parameter bit FAIR = 1'b1
) (
    input logic                  Clock,
    input logic                  Reset,
    alu_request_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, FLAG, RESP} state_t;

    state_t      state, state_next;
    logic        ptr;
    logic        grant_id;
    logic        ready0, ready1;
    logic        accept;
    logic [15:0] lat_a, lat_b;
    logic [4:0]  lat_fun;
    logic        lat_wf;
    logic        lat_id;
    logic [15:0] rsp_data;
    logic [3:0]  rsp_flags;

    always_comb begin
        state_next = state;
        grant_id   = 1'b0;
        ready0     = 1'b0;
        ready1     = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.Req0Valid && bus.Req1Valid)
                    grant_id = FAIR ? ptr : 1'b0;
                else
                    grant_id = bus.Req1Valid;
                // Ready is combinational, so it is gated off while reset holds the FSM
                if (!Reset) begin
                    ready0 = bus.Req0Valid && !grant_id;
                    ready1 = bus.Req1Valid && grant_id;
                end
                accept = ready0 || ready1;
                if (accept)
                    state_next = EXEC;
            end
            EXEC:    state_next = FLAG;
            FLAG:    state_next = RESP;
            RESP:    if (bus.RspReady) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ptr       <= 1'b0;
            lat_a     <= '0;
            lat_b     <= '0;
            lat_fun   <= '0;
            lat_wf    <= 1'b0;
            lat_id    <= 1'b0;
            rsp_data  <= '0;
            rsp_flags <= '0;
        end else begin
            if (accept) begin
                lat_a   <= grant_id ? bus.Req1A      : bus.Req0A;
                lat_b   <= grant_id ? bus.Req1B      : bus.Req0B;
                lat_fun <= grant_id ? bus.Req1FunSel : bus.Req0FunSel;
                lat_wf  <= grant_id ? bus.Req1WF     : bus.Req0WF;
                lat_id  <= grant_id;
                if (FAIR)
                    ptr <= ~grant_id;
            end
            if (state == EXEC)
                rsp_data <= bus.ALUOut;
            // Flags are registered inside the ALU, so they settle one cycle after EXEC
            if (state == FLAG)
                rsp_flags <= bus.FlagsOut;
        end
    end

    assign bus.Req0Ready = ready0;
    assign bus.Req1Ready = ready1;
    assign bus.A         = lat_a;
    assign bus.B         = lat_b;
    assign bus.FunSel    = lat_fun;
    assign bus.WF        = (state == EXEC) && lat_wf;
    assign bus.RspValid  = (state == RESP);
    assign bus.RspId     = lat_id;
    assign bus.RspData   = rsp_data;
    assign bus.RspFlags  = rsp_flags;
endmodule

// File: tb/tb_alu_request_arbiter.sv
// Directed bench for alu_request_arbiter: a small ALU model drives ALUOut/FlagsOut
// and a response scoreboard is checked whenever a response handshake occurs.
module tb_alu_request_arbiter;
    logic Clock = 1'b0;
    logic Reset;
    always #5 Clock = ~Clock;

    alu_request_arbiter_if bif ();
    alu_request_arbiter_if fif ();

    alu_request_arbiter #(.FAIR(1'b1)) dut (.Clock(Clock), .Reset(Reset), .bus(bif));
    alu_request_arbiter #(.FAIR(1'b0)) dut_fp (.Clock(Clock), .Reset(Reset), .bus(fif));

    // ALU model: op 0100 = add, anything else passes A; bit 4 selects 16-bit mode
    logic [15:0] alu_res;
    logic [3:0]  alu_flags;
    logic [3:0]  flag_reg;
    always_comb begin
        logic [16:0] s16;
        logic [8:0]  s8;
        logic        is_add, c, n, o;
        is_add = (bif.FunSel[3:0] == 4'b0100);
        s16    = {1'b0, bif.A} + {1'b0, bif.B};
        s8     = {1'b0, bif.A[7:0]} + {1'b0, bif.B[7:0]};
        if (bif.FunSel[4]) begin
            alu_res = is_add ? s16[15:0] : bif.A;
            c = is_add & s16[16];
            o = is_add & (bif.A[15] == bif.B[15]) & (alu_res[15] != bif.A[15]);
            n = alu_res[15];
        end else begin
            alu_res = {8'h00, (is_add ? s8[7:0] : bif.A[7:0])};
            c = is_add & s8[8];
            o = is_add & (bif.A[7] == bif.B[7]) & (alu_res[7] != bif.A[7]);
            n = alu_res[7];
        end
        alu_flags = {(alu_res == 16'h0000), c, n, o};
    end
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)
            flag_reg <= 4'b0000;
        else if (bif.WF)
            flag_reg <= alu_flags;
    end
    assign bif.ALUOut   = alu_res;
    assign bif.FlagsOut = flag_reg;
    assign fif.ALUOut   = 16'h0000;
    assign fif.FlagsOut = 4'b0000;

    typedef struct {
        logic        id;
        logic [15:0] data;
        logic [3:0]  flags;
    } rsp_t;
    rsp_t sb[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int id, input logic v, input logic [15:0] a, input logic [15:0] b,
                           input logic [4:0] fun, input logic wf);
        if (id == 0) begin
            bif.Req0Valid = v; bif.Req0A = a; bif.Req0B = b; bif.Req0FunSel = fun; bif.Req0WF = wf;
        end else begin
            bif.Req1Valid = v; bif.Req1A = a; bif.Req1B = b; bif.Req1FunSel = fun; bif.Req1WF = wf;
        end
    endtask

    // Present one operation, follow it through EXEC and FLAG, and return in RESP.
    task automatic do_op(input int id, input logic [15:0] a, input logic [15:0] b, input logic [4:0] fun,
                         input logic wf, input logic [15:0] ed, input logic [3:0] ef, output int waited);
        logic got, rdy, other;
        got    = 1'b0;
        waited = 0;
        set_req(id, 1'b1, a, b, fun, wf);
        #1;
        for (int i = 0; i < 12; i++) begin
            rdy = (id == 0) ? bif.Req0Ready : bif.Req1Ready;
            if (rdy) begin
                got = 1'b1;
                break;
            end
            waited++;
            @(posedge Clock); #1;
        end
        chk("grant", 16'(got), 16'h1);
        if (!got) begin
            set_req(id, 1'b0, a, b, fun, wf);
            return;
        end
        other = (id == 0) ? bif.Req1Ready : bif.Req0Ready;
        chk("grant_exclusive", 16'(other), 16'h0);
        sb.push_back('{1'(id), ed, ef});
        @(posedge Clock); #1;
        set_req(id, 1'b0, a, b, fun, wf);
        chk("exec_wf", 16'(bif.WF), 16'(wf));
        chk("exec_a", bif.A, a);
        chk("exec_b", bif.B, b);
        chk("exec_fun", 16'(bif.FunSel), 16'(fun));
        chk("exec_ready0", 16'(bif.Req0Ready), 16'h0);
        chk("exec_ready1", 16'(bif.Req1Ready), 16'h0);
        chk("exec_rspvalid", 16'(bif.RspValid), 16'h0);
        @(posedge Clock); #1;
        chk("flag_wf", 16'(bif.WF), 16'h0);
        chk("flag_rspvalid", 16'(bif.RspValid), 16'h0);
        @(posedge Clock); #1;
        chk("latency_rspvalid", 16'(bif.RspValid), 16'h1);
        chk("resp_wf", 16'(bif.WF), 16'h0);
    endtask

    // Response scoreboard: compare on each cycle that will complete a handshake
    always @(negedge Clock) begin
        if (!Reset && bif.RspValid && bif.RspReady) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 16'(bif.RspValid), 16'h0);
            end else begin
                rsp_t e;
                e = sb.pop_front();
                chk("rsp_id", 16'(bif.RspId), 16'(e.id));
                chk("rsp_data", bif.RspData, e.data);
                chk("rsp_flags", 16'(bif.RspFlags), 16'(e.flags));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        int g0;
        set_req(0, 1'b0, 16'h0, 16'h0, 5'b0, 1'b0);
        set_req(1, 1'b0, 16'h0, 16'h0, 5'b0, 1'b0);
        bif.RspReady = 1'b1;
        fif.Req0Valid = 1'b0; fif.Req1Valid = 1'b0;
        fif.Req0A = '0; fif.Req0B = '0; fif.Req1A = '0; fif.Req1B = '0;
        fif.Req0FunSel = '0; fif.Req1FunSel = '0; fif.Req0WF = 1'b0; fif.Req1WF = 1'b0;
        fif.RspReady = 1'b1;
        Reset = 1'b1;

        // Reset values, with both requesters asking to prove Ready stays low
        bif.Req0Valid = 1'b1;
        bif.Req1Valid = 1'b1;
        repeat (2) @(posedge Clock);
        #1;
        chk("rst_ready0", 16'(bif.Req0Ready), 16'h0);
        chk("rst_ready1", 16'(bif.Req1Ready), 16'h0);
        chk("rst_rspvalid", 16'(bif.RspValid), 16'h0);
        chk("rst_rspid", 16'(bif.RspId), 16'h0);
        chk("rst_rspdata", bif.RspData, 16'h0);
        chk("rst_rspflags", 16'(bif.RspFlags), 16'h0);
        chk("rst_a", bif.A, 16'h0);
        chk("rst_b", bif.B, 16'h0);
        chk("rst_fun", 16'(bif.FunSel), 16'h0);
        chk("rst_wf", 16'(bif.WF), 16'h0);
        bif.Req0Valid = 1'b0;
        bif.Req1Valid = 1'b0;
        Reset = 1'b0;

        // Req0 alone, 16-bit add with overflow, accepted on the first edge after reset
        do_op(0, 16'h7FFF, 16'h0001, 5'b10100, 1'b1, 16'h8000, 4'b0011, w);
        chk("first_accept_wait", 16'(w), 16'h0);
        @(posedge Clock); #1;
        chk("idle_rspvalid", 16'(bif.RspValid), 16'h0);

        // Round-robin from a fresh pointer: Req0, then Req1, then Req0
        Reset = 1'b1;
        @(posedge Clock); #1;
        Reset = 1'b0;
        set_req(1, 1'b1, 16'h0003, 16'h0004, 5'b10100, 1'b1);
        do_op(0, 16'h00FF, 16'h0001, 5'b00100, 1'b1, 16'h0000, 4'b1100, w);
        chk("rr_first_wait", 16'(w), 16'h0);
        chk("resp_ready1", 16'(bif.Req1Ready), 16'h0);
        set_req(0, 1'b1, 16'h0080, 16'h0080, 5'b00100, 1'b1);
        @(posedge Clock); #1;
        chk("rr_ready1", 16'(bif.Req1Ready), 16'h1);
        chk("rr_ready0", 16'(bif.Req0Ready), 16'h0);
        do_op(1, 16'h0003, 16'h0004, 5'b10100, 1'b1, 16'h0007, 4'b0000, w);
        chk("rr_second_wait", 16'(w), 16'h0);
        set_req(1, 1'b1, 16'h0003, 16'h0004, 5'b10100, 1'b1);
        do_op(0, 16'h0080, 16'h0080, 5'b00100, 1'b1, 16'h0000, 4'b1101, w);
        chk("rr_third_wait", 16'(w), 16'h1);
        set_req(1, 1'b0, 16'h0, 16'h0, 5'b0, 1'b0);
        @(posedge Clock); #1;

        // Consumer stalls for 5 cycles in RESP; WF=0 op leaves the flags alone
        bif.RspReady = 1'b0;
        do_op(1, 16'h1111, 16'h2222, 5'b10100, 1'b0, 16'h3333, 4'b1101, w);
        set_req(0, 1'b1, 16'h0, 16'h0, 5'b0, 1'b0);
        repeat (5) begin
            chk("hold_rspvalid", 16'(bif.RspValid), 16'h1);
            chk("hold_rspdata", bif.RspData, 16'h3333);
            chk("hold_ready0", 16'(bif.Req0Ready), 16'h0);
            @(posedge Clock); #1;
        end
        bif.RspReady = 1'b1;
        set_req(0, 1'b0, 16'h0, 16'h0, 5'b0, 1'b0);
        @(posedge Clock); #1;
        chk("hold_done", 16'(bif.RspValid), 16'h0);

        // Reset pulse in EXEC discards the operation
        set_req(0, 1'b1, 16'h5555, 16'h1111, 5'b10100, 1'b1);
        #1;
        chk("abort_ready0", 16'(bif.Req0Ready), 16'h1);
        @(posedge Clock); #1;
        set_req(0, 1'b0, 16'h0, 16'h0, 5'b0, 1'b0);
        chk("abort_exec_wf", 16'(bif.WF), 16'h1);
        Reset = 1'b1;
        #1;
        chk("abort_wf", 16'(bif.WF), 16'h0);
        chk("abort_rspvalid", 16'(bif.RspValid), 16'h0);
        chk("abort_a", bif.A, 16'h0);
        chk("abort_b", bif.B, 16'h0);
        chk("abort_fun", 16'(bif.FunSel), 16'h0);
        chk("abort_rspdata", bif.RspData, 16'h0);
        chk("abort_rspflags", 16'(bif.RspFlags), 16'h0);
        chk("abort_rspid", 16'(bif.RspId), 16'h0);
        @(posedge Clock); #1;
        Reset = 1'b0;
        repeat (4) begin
            @(posedge Clock); #1;
            chk("abort_no_rsp", 16'(bif.RspValid), 16'h0);
        end
        do_op(0, 16'h0001, 16'h0002, 5'b10100, 1'b1, 16'h0003, 4'b0000, w);
        chk("after_abort_wait", 16'(w), 16'h0);
        @(posedge Clock); #1;

        // Flag-writing add, then a pass-through with WF=0 that must see the same flags
        do_op(0, 16'hFFFF, 16'h0001, 5'b10100, 1'b1, 16'h0000, 4'b1100, w);
        do_op(1, 16'h1234, 16'h0000, 5'b10000, 1'b0, 16'h1234, 4'b1100, w);
        @(posedge Clock); #1;
        @(posedge Clock); #1;
        chk("sb_empty", 16'(sb.size()), 16'h0);

        // Fixed-priority instance: Req0 wins every time both ask
        fif.Req0Valid = 1'b1;
        fif.Req1Valid = 1'b1;
        g0 = 0;
        #1;
        for (int i = 0; i < 16; i++) begin
            chk("fp_ready1", 16'(fif.Req1Ready), 16'h0);
            if (fif.Req0Ready)
                g0++;
            @(posedge Clock); #1;
        end
        chk("fp_req0_grants", 16'(g0 >= 3), 16'h1);
        fif.Req0Valid = 1'b0;
        fif.Req1Valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
